oup_wb_master: RTL and testbench

- Wishbone B4 classic single-transfer initiator that issues one read or write per command on a simple valid/ready command port.
- Returns read data and a status code on a valid/ready response port.
- Gives FPGA-side logic the initiator end of the same Wishbone interface the NEORV32 drives, so that `oup_wishbone` (or any other slave) can be driven and exercised without the CPU.
- Includes a bus timeout, so that a hung slave cannot stall the command source.

---
 rtl/oup_wb_master.sv | 190 +++++++++++++++++++
 tb/tb_oup_wb_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oup_wb_master.sv
// -----------------------------------------------------------------------------
// oup_wb_master
//   A Wishbone B4 classic initiator that performs one transfer at a time. Each
//   command taken on the cmd_* valid/ready port becomes a single read or write
//   bus cycle. The read data and a status code come back on the rsp_* port.
//   A bus timeout ends a cycle that a slave never terminates, so the command
//   source can always make progress.
//
// Parameters
//   TIMEOUT_CYCLES : number of BUS cycles without ack/err before the cycle is
//                    aborted (0..65535; 0 disables the timeout)
//   TAG            : constant driven on wb_tag_o while wb_cyc_o is high
//
// Ports
//   clk_i, rstn_i         clock; synchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (cmd_ready_o = 1 only in IDLE)
//   cmd_we_i/adr_i/dat_i/sel_i  command fields, sampled at acceptance only
//   rsp_valid_o/ready_i   response handshake
//   rsp_dat_o             read data (0 for writes, errors and timeouts)
//   rsp_status_o          00 OK, 01 ERR, 10 TIMEOUT
//   wb_*                  Wishbone initiator signals; every output registered
// -----------------------------------------------------------------------------
module oup_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [2:0]  TAG            = 3'b000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  // Wishbone initiator
  output logic [2:0]  wb_tag_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value seen in the last permitted BUS cycle.
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        cyc_q, cyc_d;
  logic [2:0]  tag_q, tag_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  status_e     rsp_status_q, rsp_status_d;

  always_comb begin
    // NOTE: every _d starts as its _q so each path assigns everything and no
    // latch can be inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    sel_d        = sel_q;
    cyc_d        = cyc_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          dat_d   = cmd_we_i ? cmd_dat_i : 32'd0;
          cyc_d   = 1'b1;
          tag_d   = TAG;
          cnt_d   = 16'd0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        // err beats ack; an ack in the timeout cycle still completes as OK.
        if (wb_err_i || wb_ack_i || (TO_EN && cnt_q == TO_LAST)) begin
          if (wb_err_i) begin
            rsp_status_d = ST_ERR;
            rsp_dat_d    = 32'd0;
          end else if (wb_ack_i) begin
            rsp_status_d = ST_OK;
            rsp_dat_d    = we_q ? 32'd0 : wb_dat_i;
          end else begin
            rsp_status_d = ST_TIMEOUT;
            rsp_dat_d    = 32'd0;
          end
          cyc_d       = 1'b0;
          tag_d       = 3'd0;
          adr_d       = 32'd0;
          dat_d       = 32'd0;
          sel_d       = 4'd0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      adr_q        <= 32'd0;
      dat_q        <= 32'd0;
      we_q         <= 1'b0;
      sel_q        <= 4'd0;
      cyc_q        <= 1'b0;
      tag_q        <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= 32'd0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      cyc_q        <= cyc_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_tag_o     = tag_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = sel_q;
  assign wb_stb_o     = cyc_q;
  assign wb_cyc_o     = cyc_q;

endmodule

// File: tb/tb_oup_wb_master.sv
// -----------------------------------------------------------------------------
// tb_oup_wb_master
//   Directed self-checking bench for oup_wb_master (TIMEOUT_CYCLES=8, TAG=5).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_oup_wb_master;

  localparam logic [2:0] TAG_V = 3'b101;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [2:0]  wb_tag;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
  logic [3:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oup_wb_master #(.TIMEOUT_CYCLES(8), .TAG(TAG_V)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wb_tag_o(wb_tag), .wb_adr_o(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for exactly one edge, then scrambles the fields to
  // show they are only sampled at acceptance.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = 32'hFFFF_FFFF;
    cmd_dat = 32'h5555_5555; cmd_sel = 4'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_dat, rsp_status} !== {1'b1, 1'b0, 32'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_rsp: got rdy=%b vld=%b dat=%h st=%b, expected rdy=1 vld=0 dat=0 st=00",
               cmd_ready, rsp_valid, rsp_dat, rsp_status);
    end
    checks++;
    if ({wb_tag, wb_adr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc} !== 74'd0) begin
      errors++;
      $display("FAIL reset_wb: got tag=%h adr=%h dat=%h we=%b sel=%h stb=%b cyc=%b, expected all 0",
               wb_tag, wb_adr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc);
    end
    rstn = 1'b1;
    step();
  endtask

  // Zero-wait write; returns with the response consumed.
  task automatic test_write_zero_wait();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready_before: got %b expected 1", cmd_ready);
    end
    wb_dat_i = 32'hCAFE_F00D;
    issue(1'b1, 32'h9000_0004, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if ({cmd_ready, wb_cyc, wb_stb, wb_we, wb_tag, wb_sel} !== {1'b0, 1'b1, 1'b1, 1'b1, TAG_V, 4'hF}) begin
      errors++;
      $display("FAIL wr_bus_ctl: got rdy=%b cyc=%b stb=%b we=%b tag=%h sel=%h, expected 0 1 1 1 5 f",
               cmd_ready, wb_cyc, wb_stb, wb_we, wb_tag, wb_sel);
    end
    checks++;
    if ({wb_adr, wb_dat_o} !== {32'h9000_0004, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL wr_bus_data: got adr=%h dat=%h expected 90000004 deadbeef", wb_adr, wb_dat_o);
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_tag, wb_adr, wb_dat_o, wb_sel} !== 74'd0) begin
      errors++;
      $display("FAIL wr_bus_release: got cyc=%b we=%b adr=%h dat=%h, expected all 0",
               wb_cyc, wb_we, wb_adr, wb_dat_o);
    end
    checks++;
    if ({rsp_valid, rsp_status, rsp_dat, cmd_ready} !== {1'b1, 2'b00, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL wr_rsp: got vld=%b st=%b dat=%h rdy=%b, expected 1 00 0 0",
               rsp_valid, rsp_status, rsp_dat, cmd_ready);
    end
    step();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_ready_after: got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait3();
    int n = 0;
    issue(1'b0, 32'h9000_0010, 32'hFFFF_FFFF, 4'h3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wb_cyc, wb_stb, wb_we, wb_dat_o, wb_adr} !== {1'b1, 1'b1, 1'b0, 32'd0, 32'h9000_0010}) begin
        errors++;
        $display("FAIL rd_bus_cycle%0d: got cyc=%b we=%b dat_o=%h adr=%h, expected 1 0 0 90000010",
                 i, wb_cyc, wb_we, wb_dat_o, wb_adr);
      end
      if (i == 3) begin wb_ack = 1'b1; wb_dat_i = 32'h1234_5678; end
      step();
    end
    wb_ack = 1'b0;
    wb_dat_i = 32'h0;
    checks++;
    if ({wb_cyc, rsp_valid, rsp_status, rsp_dat} !== {1'b0, 1'b1, 2'b00, 32'h1234_5678}) begin
      errors++;
      $display("FAIL rd_rsp: got cyc=%b vld=%b st=%b dat=%h, expected 0 1 00 12345678",
               wb_cyc, rsp_valid, rsp_status, rsp_dat);
    end
    while (rsp_valid === 1'b1 && n < 10) begin n++; step(); end
  endtask

  task automatic test_error();
    issue(1'b0, 32'h9000_0008, 32'h0, 4'hF);
    step();
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++; $display("FAIL err_cyc_2nd: got %b expected 1", wb_cyc);
    end
    wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = 32'h7777_7777;
    step();
    wb_err = 1'b0; wb_ack = 1'b0;
    checks++;
    if ({wb_cyc, rsp_valid, rsp_status, rsp_dat} !== {1'b0, 1'b1, 2'b01, 32'd0}) begin
      errors++;
      $display("FAIL err_rsp: got cyc=%b vld=%b st=%b dat=%h, expected 0 1 01 0",
               wb_cyc, rsp_valid, rsp_status, rsp_dat);
    end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(1'b0, 32'h9000_000C, 32'h0, 4'hF);
    while (wb_cyc === 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL to_cyc_len: got %0d cycles expected 8", n);
    end
    checks++;
    if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b10, 32'd0}) begin
      errors++;
      $display("FAIL to_rsp: got vld=%b st=%b dat=%h, expected 1 10 0", rsp_valid, rsp_status, rsp_dat);
    end
    step();
    step();
    wb_ack = 1'b1; wb_dat_i = 32'h1111_2222;
    step();
    wb_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rsp_valid, wb_cyc, cmd_ready} !== 3'b001) begin
        errors++;
        $display("FAIL to_late_ack%0d: got vld=%b cyc=%b rdy=%b expected 0 0 1",
                 i, rsp_valid, wb_cyc, cmd_ready);
      end
      step();
    end
  endtask

  // Ack in the very cycle the timeout would fire: OK must win.
  task automatic test_ack_at_timeout();
    issue(1'b0, 32'h9000_0014, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++; $display("FAIL ackto_cyc8: got %b expected 1", wb_cyc);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    step();
    wb_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL ackto_rsp: got vld=%b st=%b dat=%h, expected 1 00 0badf00d",
               rsp_valid, rsp_status, rsp_dat);
    end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b0, 32'h9000_0018, 32'h0, 4'hF);
    wb_ack = 1'b1; wb_dat_i = 32'hA5A5_0F0F;
    step();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    // A new command waits at the port during the stall.
    cmd_we = 1'b1; cmd_adr = 32'h9000_0020; cmd_dat = 32'h0000_00AB; cmd_sel = 4'h1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_status, rsp_dat, cmd_ready, wb_cyc} !== {1'b1, 2'b00, 32'hA5A5_0F0F, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b st=%b dat=%h rdy=%b cyc=%b, expected 1 00 a5a50f0f 0 0",
                 i, rsp_valid, rsp_status, rsp_dat, cmd_ready, wb_cyc);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if ({rsp_valid, cmd_ready, wb_cyc} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, wb_cyc);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({wb_cyc, wb_we, wb_adr, wb_dat_o, wb_sel} !== {1'b1, 1'b1, 32'h9000_0020, 32'h0000_00AB, 4'h1}) begin
      errors++;
      $display("FAIL bp_next_cmd: got cyc=%b we=%b adr=%h dat=%h sel=%h, expected 1 1 90000020 000000ab 1",
               wb_cyc, wb_we, wb_adr, wb_dat_o, wb_sel);
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'd0}) begin
      errors++;
      $display("FAIL bp_next_rsp: got vld=%b st=%b dat=%h expected 1 00 0", rsp_valid, rsp_status, rsp_dat);
    end
    step();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 32'h9000_0030, 32'h3333_4444, 4'hC);
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_bus: got cyc=%b expected 1", wb_cyc);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_dat, rsp_status, wb_tag, wb_adr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc}
        !== {1'b1, 109'd0}) begin
      errors++;
      $display("FAIL rstmid_outputs: got rdy=%b vld=%b cyc=%b stb=%b adr=%h dat=%h, expected 1 then all 0",
               cmd_ready, rsp_valid, wb_cyc, wb_stb, wb_adr, wb_dat_o);
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++;
    if ({rsp_valid, wb_cyc, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_late_ack: got vld=%b cyc=%b rdy=%b expected 0 0 1", rsp_valid, wb_cyc, cmd_ready);
    end
    test_write_zero_wait();
  endtask

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1; wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_error();
    test_timeout();
    test_ack_at_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
